// File: rtl/flag_pkg.sv
// flag_pkg: shared flag layout, opcode constants and per-opcode flag update masks
package flag_pkg;
  typedef struct packed {
    logic c;
    logic z;
    logic v;
    logic n;
  } flags_t;
  localparam int OP_ADD = 'h0;
  localparam int OP_SUB = 'h1;
  localparam int OP_AND = 'h3;
  localparam int OP_OR  = 'h4;
  localparam int OP_XOR = 'h5;
  localparam int OP_SRA = 'h6;
  localparam flags_t MASK_ALL  = 4'b1111;
  localparam flags_t MASK_Z    = 4'b0100;
  localparam flags_t MASK_NONE = 4'b0000;
  function automatic flags_t flag_mask(input logic [31:0] opcode);
    return (opcode == OP_ADD || opcode == OP_SUB) ? MASK_ALL :
           (opcode >= OP_AND && opcode <= OP_SRA) ? MASK_Z : MASK_NONE;
  endfunction
endpackage

// File: rtl/flag_stack.sv
// flag_stack: LIFO of flags_t used to shadow flags across interrupt entry/return
// Ports: clk, rst (sync, active-high); en qualifies push/pop; din is the value pushed;
// top is the newest entry; empty/full reflect depth; err pulses on conflict/overflow/underflow.
module flag_stack
  import flag_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int DW = AW + 1
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   en,
  input  logic   push,
  input  logic   pop,
  input  flags_t din,
  output flags_t top,
  output logic   empty,
  output logic   full,
  output logic   err
);
  flags_t mem [DEPTH];
  logic [DW-1:0] depth;
  logic do_push, do_pop;
  always_comb begin
    empty = depth == '0;
    full = depth == DW'(DEPTH);
    do_push = en && push && !pop && !full;
    do_pop = en && pop && !push && !empty;
    err = en && ((push && pop) || (push && full) || (pop && empty));
    top = mem[AW'(depth - 1'b1)];
  end
  always_ff @(posedge clk) begin
    if (rst) depth <= '0;
    else if (do_push) depth <= depth + 1'b1;
    else if (do_pop) depth <= depth - 1'b1;
  end
  always_ff @(posedge clk) begin
    if (do_push) mem[depth[AW-1:0]] <= din;
  end
endmodule

// File: rtl/flag_unit.sv
// flag_unit: {c,z,v,n} status-flag register with per-opcode masks, stall gating and shadow stack
// Ports: clk, rst (sync, active-high); valid/stall qualify the EX instruction; opcode, aluout,
// aluovfl, alucarry form the candidate flags; push/pop save/restore flags on interrupt entry/return;
// flag is the committed value, flag_next its next-edge value; stack_empty/full/err report the stack.
// Macro FLAG_UNIT_BYPASS_EN: when defined flag_next is the combinational next value, else flag.
module flag_unit
  import flag_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int OPC_W = 4,
  parameter int STACK_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid,
  input  logic              stall,
  input  logic [OPC_W-1:0]  opcode,
  input  logic [DATA_W-1:0] aluout,
  input  logic              aluovfl,
  input  logic              alucarry,
  input  logic              push,
  input  logic              pop,
  output logic [3:0]        flag,
  output logic [3:0]        flag_next,
  output logic              stack_empty,
  output logic              stack_full,
  output logic              stack_err
);
  flags_t cur, cand, m, upd_val, top, nxt;
  logic adv, err_pulse;
  assign adv = !stall;
  always_comb begin
    m = (valid && adv) ? flag_mask(32'(opcode)) : MASK_NONE;
    cand = '{c: alucarry, z: aluout == '0, v: aluovfl, n: aluout[DATA_W-1]};
    upd_val = (cur & ~m) | (cand & m);
    // a lone pop overrides the ALU result; popping an empty stack keeps the old flags
    nxt = rst ? '0 : !adv ? cur : (pop && !push) ? (stack_empty ? cur : top) : upd_val;
  end
  flag_stack #(.DEPTH(STACK_DEPTH)) u_stack (
    .clk(clk),
    .rst(rst),
    .en(adv),
    .push(push),
    .pop(pop),
    .din(upd_val),
    .top(top),
    .empty(stack_empty),
    .full(stack_full),
    .err(err_pulse)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      cur <= '0;
      stack_err <= 1'b0;
    end else begin
      cur <= nxt;
      if (err_pulse) stack_err <= 1'b1;
    end
  end
  assign flag = cur;
`ifdef FLAG_UNIT_BYPASS_EN
  assign flag_next = nxt;
`else
  assign flag_next = cur;
`endif
endmodule

// File: tb/tb_flag_unit.sv
// tb_flag_unit: scoreboard bench for flag_unit against a queue-based flag/stack model
module tb_flag_unit;
  logic clk = 0, rst = 1, valid = 0, stall = 0, aluovfl = 0, alucarry = 0, push = 0, pop = 0;
  logic [3:0] opcode = 0;
  logic [15:0] aluout = 0;
  logic [3:0] flag, flag_next;
  logic stack_empty, stack_full, stack_err;
  typedef struct {
    logic [3:0] f;
    logic [3:0] fn;
    logic e;
    logic fu;
    logic er;
  } exp_t;
  exp_t q[$];
  logic [3:0] mstk[$];
  logic [3:0] mf = 0;
  logic merr = 0;
  int passed = 0, total = 0;
  always #5 clk = ~clk;
  flag_unit #(.DATA_W(16), .OPC_W(4), .STACK_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .valid(valid), .stall(stall), .opcode(opcode), .aluout(aluout),
    .aluovfl(aluovfl), .alucarry(alucarry), .push(push), .pop(pop), .flag(flag),
    .flag_next(flag_next), .stack_empty(stack_empty), .stack_full(stack_full), .stack_err(stack_err)
  );
  function automatic logic [3:0] mask_of(input logic [3:0] op);
    if (op <= 1) return 4'hF;
    if (op >= 3 && op <= 6) return 4'h4;
    return 4'h0;
  endfunction
  task automatic chk(input string nm, input logic [3:0] a, input logic [3:0] e);
    total++;
    if (a === e) passed++;
    else $display("FAIL %s: got %h want %h", nm, a, e);
  endtask
  task automatic step(input logic r, v, s, input logic [3:0] op, input logic [15:0] a,
                      input logic ov, cy, pu, po);
    logic [3:0] cand, m, u, nf;
    exp_t x;
    @(posedge clk);
    #1;
    rst = r; valid = v; stall = s; opcode = op; aluout = a;
    aluovfl = ov; alucarry = cy; push = pu; pop = po;
    x.f = mf; x.e = mstk.size() == 0; x.fu = mstk.size() == 4; x.er = merr;
    m = v ? mask_of(op) : 4'h0;
    cand = {cy, a == 16'h0, ov, a[15]};
    u = (mf & ~m) | (cand & m);
    nf = u;
    if (r) begin
      nf = 0; merr = 0; mstk.delete();
    end else if (s) nf = mf;
    else if (po && !pu) begin
      if (mstk.size() > 0) nf = mstk.pop_back();
      else begin nf = mf; merr = 1; end
    end else if (po && pu) merr = 1;
    else if (pu) begin
      if (mstk.size() < 4) mstk.push_back(u);
      else merr = 1;
    end
`ifdef FLAG_UNIT_BYPASS_EN
    x.fn = nf;
`else
    x.fn = mf;
`endif
    q.push_back(x);
    mf = nf;
  endtask
  task automatic alu(input logic [3:0] op, input logic [15:0] a, input logic ov, cy, pu, po);
    step(0, 1, 0, op, a, ov, cy, pu, po);
  endtask
  initial begin
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        exp_t x;
        x = q.pop_front();
        chk("flag", flag, x.f);
        chk("flag_next", flag_next, x.fn);
        chk("stack_empty", {3'b0, stack_empty}, {3'b0, x.e});
        chk("stack_full", {3'b0, stack_full}, {3'b0, x.fu});
        chk("stack_err", {3'b0, stack_err}, {3'b0, x.er});
      end
    end
  end
  initial begin
    repeat (2) @(posedge clk);
    alu(4'h0, 16'h0000, 0, 1, 0, 0);
    alu(4'h1, 16'h8000, 1, 0, 0, 0);
    alu(4'h0, 16'h8000, 1, 1, 0, 0);
    alu(4'h3, 16'h0000, 0, 0, 0, 0);
    alu(4'h4, 16'h0001, 0, 0, 0, 0);
    alu(4'h2, 16'h0000, 0, 0, 0, 0);
    step(0, 1, 1, 4'h0, 16'h0000, 0, 0, 1, 0);
    step(0, 1, 1, 4'h0, 16'h0000, 0, 0, 1, 0);
    alu(4'h0, 16'h0000, 0, 0, 1, 0);
    alu(4'h2, 16'h0000, 0, 0, 0, 1);
    alu(4'h0, 16'h8000, 0, 0, 1, 0);
    alu(4'h0, 16'h0001, 1, 0, 1, 0);
    alu(4'h0, 16'h8000, 1, 0, 1, 0);
    alu(4'h0, 16'h0000, 0, 0, 1, 0);
    alu(4'h0, 16'h0001, 0, 0, 1, 0);
    repeat (5) alu(4'h2, 16'h0001, 0, 0, 0, 1);
    step(1, 0, 0, 4'h0, 16'h0, 0, 0, 0, 0);
    alu(4'h0, 16'h0001, 0, 0, 0, 0);
    alu(4'h0, 16'h0000, 0, 0, 1, 0);
    alu(4'h0, 16'h8000, 0, 0, 1, 0);
    alu(4'h0, 16'h0000, 0, 0, 0, 1);
    alu(4'h0, 16'h0000, 0, 1, 1, 1);
    alu(4'h2, 16'h0000, 0, 0, 1, 0);
    step(1, 0, 0, 4'h0, 16'h0, 0, 0, 0, 0);
    step(0, 0, 0, 4'h0, 16'h0, 0, 0, 0, 0);
    for (int i = 0; i < 400; i++) begin
      logic [15:0] a;
      a = $urandom_range(0, 3) == 0 ? 16'h0000 : $urandom_range(0, 3) == 0 ? 16'h8000 : 16'($urandom);
      step($urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
           4'($urandom_range(0, 15)), a, 1'($urandom), 1'($urandom),
           $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
    end
    repeat (2) step(0, 0, 0, 4'h0, 16'h0, 0, 0, 0, 0);
    for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      total++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/flag_unit.md
Name: flag_unit

Overview:
- Parametrised successor to the processor's z/v/n status-flag register.
- Adds a carry flag, per-opcode update masks from a shared decode table, an explicit valid qualifier and stall gating.
- Adds a STACK_DEPTH-entry shadow stack so flags are saved/restored across interrupt entry/return.
- Sits at the end of EX; feeds the branch-resolution logic.

Parameters:
- DATA_W, 16, ALU result width.
- OPC_W, 4, opcode width.
- STACK_DEPTH, 4, shadow-stack entries (power of 2, >=2).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- valid  in  1  EX-stage instruction valid.
- stall  in  1  pipeline stall; freezes all state.
- opcode  in  OPC_W  EX-stage opcode.
- aluout  in  DATA_W  ALU result.
- aluovfl  in  1  signed overflow from ALU.
- alucarry  in  1  carry-out from ALU.
- push  in  1  save flags (interrupt entry).
- pop  in  1  restore flags (interrupt return).
- flag  out  4  committed flags {c,z,v,n}.
- flag_next  out  4  value flag takes at the next edge (branch bypass).
- stack_empty  out  1  depth==0.
- stack_full  out  1  depth==STACK_DEPTH.
- stack_err  out  1  sticky overflow/underflow/conflict error.

Behaviour:
- Reset (synchronous, active-high) clears flag=0, depth=0 and stack_err=0. Stack contents are don't-care after reset. stack_empty=1 and stack_full=0 after reset.
- adv = !stall. When stall=1, nothing changes: flag, stack, depth and stack_err all hold. push and pop are ignored during a stall.
- Update mask m = flag_mask(opcode) from the package:
  - ADD (0x0) and SUB (0x1): m=4'b1111.
  - 0x3, 0x4, 0x5, 0x6: m=4'b0100 (z only).
  - All other opcodes: m=0.
- Candidate flags: z=(aluout==0), v=aluovfl, n=aluout[DATA_W-1], c=alucarry.
- upd = valid && adv. For each bit i, flag[i] <= m[i] ? cand[i] : flag[i].
- Priority within one advancing cycle:
  1. pop && !push && depth>0: flag <= stack[depth-1], depth--. Any ALU update in the same cycle is discarded.
  2. push && !pop && depth<STACK_DEPTH: stack[depth] <= flag_next_upd (post-update value), depth++. The ALU update still commits to flag.
  3. push && pop together: stack untouched, ALU update commits, stack_err <= 1.
  4. push when full: push dropped, update commits, stack_err <= 1.
  5. pop when empty: flag unchanged (the ALU update is also discarded), stack_err <= 1.
- stack_err is cleared only by rst.
- Latency: flag reflects an instruction one cycle after its upd edge.
- No wrap-around: depth saturates at 0 and STACK_DEPTH.

Optional Feature:
- Macro: FLAG_UNIT_BYPASS_EN.
- Defined: flag_next is combinational and equals exactly what flag will hold after the next edge (including pop restore and stall hold).
- Undefined: flag_next is tied to flag. Branch logic then sees flags one cycle later, and the pipeline must insert a bubble.

Decomposition:
- Package flag_pkg holds:
  - typedef flags_t packed {c,z,v,n};
  - opcode localparams OP_ADD, OP_SUB, OP_AND..OP_SRA (0x3-0x6);
  - function flag_mask(opcode) returning a 4-bit mask.
- One sub-module, flag_stack: a LIFO of flags_t with push/pop/depth/full/empty and error outputs. flag_unit instantiates it and owns the priority logic.

Test Plan:
- Reset, then ADD with aluout=16'h0000, aluovfl=0, alucarry=1, valid=1 -> next cycle flag=4'b1100. Then SUB with aluout=16'h8000, ovfl=1 -> flag=4'b0011.
- With flag=4'b1111, opcode 0x4, aluout=16'h0001 -> flag=4'b1011 (only z cleared). Opcode 0x2, aluout=0 -> flag unchanged.
- stall=1 with ADD aluout=0 and push=1 -> flag, depth and stack_err unchanged. Deassert stall -> update commits and depth becomes 1.
- Push 4 times with flags 1,2,3,4 -> stack_full=1. 5th push -> stack_err=1, depth stays 4. Pop 4 times -> flag sequence 4,3,2,1, then stack_empty=1. Extra pop -> flag holds, stack_err stays 1.
- Same cycle: ADD aluout=0 and push=1 with flag=0 -> stack entry=4'b0100 and flag=4'b0100. Same cycle: ADD and pop, top=4'b0001 -> flag=4'b0001 (update discarded). Same cycle: push and pop -> stack_err=1, depth unchanged.
- rst asserted mid-sequence at depth=3, stack_err=1 -> next cycle flag=0, depth=0, stack_empty=1, stack_err=0. With FLAG_UNIT_BYPASS_EN defined, flag_next equals the post-edge flag every cycle; undefined, flag_next==flag always.
